// File: rtl/traffic_light_ped_ctrl.sv
// Pedestrian-actuated NS crossing controller: GREEN rests until a request,
// then runs YELLOW -> RED/WALK -> RED/CLEAR back to GREEN.
module traffic_light_ped_ctrl #(
    parameter int MIN_GREEN  = 4,
    parameter int YELLOW_CYC = 2,
    parameter int WALK_CYC   = 5,
    parameter int CLEAR_CYC  = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic [1:0] NS_traffic_light,
    output logic       PED_light,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_WALK   = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] NS_GREEN  = 2'b00;
    localparam logic [1:0] NS_YELLOW = 2'b01;
    localparam logic [1:0] NS_RED    = 2'b10;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req_q;

    assign state_dbg = state;

    // Outputs are loaded together with the next state, so they only ever
    // reflect the state register and never follow button combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_GREEN;
            cnt              <= '0;
            req_q            <= 1'b0;
            NS_traffic_light <= NS_GREEN;
            PED_light        <= 1'b0;
        end else begin
            case (state)
                S_GREEN: begin
                    req_q <= req_q | button;
                    if (cnt >= MG_LAST && (req_q || button)) begin
                        state            <= S_YELLOW;
                        cnt              <= '0;
                        NS_traffic_light <= NS_YELLOW;
                        PED_light        <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_YELLOW: begin
                    if (cnt == Y_LAST) begin
                        state            <= S_WALK;
                        cnt              <= '0;
                        req_q            <= 1'b0;
                        NS_traffic_light <= NS_RED;
                        PED_light        <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                        req_q <= req_q | button;
                    end
                end
                S_WALK: begin
                    // Presses while pedestrians already walk are not latched.
                    if (cnt == W_LAST) begin
                        state            <= S_CLEAR;
                        cnt              <= '0;
                        NS_traffic_light <= NS_RED;
                        PED_light        <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_CLEAR: begin
                    req_q <= req_q | button;
                    if (cnt == C_LAST) begin
                        state            <= S_GREEN;
                        cnt              <= '0;
                        NS_traffic_light <= NS_GREEN;
                        PED_light        <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state            <= S_GREEN;
                    cnt              <= '0;
                    req_q            <= 1'b0;
                    NS_traffic_light <= NS_GREEN;
                    PED_light        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_ped_ctrl.sv
// Bench for traffic_light_ped_ctrl: directed scenarios plus random presses,
// checked every cycle against a schedule-based reference model.
module tb_traffic_light_ped_ctrl;

    localparam int MIN_GREEN  = 4;
    localparam int YELLOW_CYC = 2;
    localparam int WALK_CYC   = 5;
    localparam int CLEAR_CYC  = 2;
    localparam int CNT_W      = 8;

    // Expected outputs packed as {NS, PED}.
    localparam logic [2:0] O_GREEN  = 3'b000;
    localparam logic [2:0] O_YELLOW = 3'b010;
    localparam logic [2:0] O_WALK   = 3'b101;
    localparam logic [2:0] O_CLEAR  = 3'b100;

    logic       clk;
    logic       reset;
    logic       button;
    logic [1:0] NS_traffic_light;
    logic       PED_light;
    logic [1:0] state_dbg;

    int tests_run;
    int tests_failed;

    // Reference model: current expected output, queue of scheduled outputs
    // for a served request, cycles spent in green, and a pending request.
    logic [2:0] cur;
    logic [2:0] sched_q[$];
    int         green_age;
    logic       pending;

    traffic_light_ped_ctrl #(
        .MIN_GREEN (MIN_GREEN),
        .YELLOW_CYC(YELLOW_CYC),
        .WALK_CYC  (WALK_CYC),
        .CLEAR_CYC (CLEAR_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .button          (button),
        .NS_traffic_light(NS_traffic_light),
        .PED_light       (PED_light),
        .state_dbg       (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur       = O_GREEN;
        sched_q   = {};
        green_age = 0;
        pending   = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic [2:0] nxt;
        if (cur == O_GREEN) begin
            if (green_age >= MIN_GREEN - 1 && (pending || b)) begin
                for (int i = 0; i < YELLOW_CYC; i++) sched_q.push_back(O_YELLOW);
                for (int i = 0; i < WALK_CYC; i++)   sched_q.push_back(O_WALK);
                for (int i = 0; i < CLEAR_CYC; i++)  sched_q.push_back(O_CLEAR);
                pending = 1'b1;
                cur     = sched_q.pop_front();
            end else begin
                green_age++;
                pending = pending | b;
            end
        end else begin
            if (cur != O_WALK) pending = pending | b;
            nxt = (sched_q.size() > 0) ? sched_q.pop_front() : O_GREEN;
            if (nxt == O_WALK && cur != O_WALK) pending = 1'b0;
            if (nxt == O_GREEN) green_age = 0;
            cur = nxt;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk(tag, {NS_traffic_light, PED_light}, cur);
        chk("inv_ped_only_on_red", {2'b00, PED_light && (NS_traffic_light != 2'b10)}, 3'b000);
        chk("inv_ns_never_11", {2'b00, NS_traffic_light == 2'b11}, 3'b000);
    endtask

    task automatic tick(input logic b, input string tag);
        button = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        button = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs("reset_state");
        reset = 1'b1;
    endtask

    initial begin
        int guard;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        button       = 1'b0;
        model_reset();

        // Idle: no request keeps GREEN for 50 cycles.
        do_reset();
        for (int i = 0; i < 50; i++) tick(1'b0, "idle_green");

        // Single press at cycle 10 after reset, then the full sequence.
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, "pre_press");
        tick(1'b1, "press_c10");
        for (int i = 0; i < 16; i++) tick(1'b0, "seq_after_press");

        // Early press before min green elapses is latched and served later.
        do_reset();
        tick(1'b0, "early_c0");
        tick(1'b1, "early_press");
        for (int i = 0; i < 18; i++) tick(1'b0, "early_seq");

        // Press during WALK only is ignored; press during CLEAR re-runs.
        tick(1'b1, "walk_test_start");
        guard = 0;
        while (cur != O_WALK && guard < 20) begin
            tick(1'b0, "to_walk");
            guard++;
        end
        chk("reach_walk", cur, O_WALK);
        tick(1'b1, "press_in_walk");
        guard = 0;
        while (cur != O_GREEN && guard < 20) begin
            tick(1'b0, "walk_to_green");
            guard++;
        end
        for (int i = 0; i < 12; i++) tick(1'b0, "stay_green_after_walk_press");
        tick(1'b1, "second_req");
        guard = 0;
        while (cur != O_CLEAR && guard < 20) begin
            tick(1'b0, "to_clear");
            guard++;
        end
        chk("reach_clear", cur, O_CLEAR);
        tick(1'b1, "press_in_clear");
        for (int i = 0; i < 20; i++) tick(1'b0, "clear_press_served");

        // Button held high continuously.
        for (int i = 0; i < 40; i++) tick(1'b1, "held_button");
        for (int i = 0; i < 15; i++) tick(1'b0, "held_release");

        // Long idle saturates the dwell counter; a press is still served at once.
        for (int i = 0; i < 300; i++) tick(1'b0, "saturate_idle");
        tick(1'b1, "press_after_saturation");
        chk("yellow_after_saturation", {NS_traffic_light, PED_light}, O_YELLOW);
        for (int i = 0; i < 12; i++) tick(1'b0, "sat_seq");

        // Asynchronous reset mid-WALK, with button held during reset.
        tick(1'b1, "pre_async");
        guard = 0;
        while (cur != O_WALK && guard < 20) begin
            tick(1'b0, "async_to_walk");
            guard++;
        end
        tick(1'b0, "mid_walk");
        chk("in_walk_before_reset", {NS_traffic_light, PED_light}, O_WALK);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_reset_immediate", {NS_traffic_light, PED_light}, O_GREEN);
        button = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs("held_in_reset");
        end
        button = 1'b0;
        reset  = 1'b1;
        for (int i = 0; i < 20; i++) tick(1'b0, "after_reset_no_request");

        // Random presses against the reference model.
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
